// File: rtl/store_drain_buffer.sv
// Captures core stores that hit an address window into a first-word-fall-through
// FIFO and presents them, oldest first, on a valid/ready drain port.
module store_drain_buffer #(
   parameter int          DEPTH    = 8,
   parameter logic [31:0] WIN_BASE = 32'h0000_1000,
   parameter logic [31:0] WIN_MASK = 32'hFFFF_F000
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       MemWrite,
   input  logic [31:0]                ALUResult,
   input  logic [31:0]                WriteData,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [31:0]                out_addr,
   output logic [31:0]                out_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       overflow,
   input  logic                       clr_overflow
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   logic [63:0]   mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic          in_win;
   logic          push;
   logic          pop;
   logic          drop;

   assign in_win = (ALUResult & WIN_MASK) == (WIN_BASE & WIN_MASK);
   assign full   = (count == CNT_FULL);
   assign empty  = (count == '0);

   assign out_valid = !empty;
   assign pop       = out_valid && out_ready;
   // A pop in the same cycle frees the slot, so a full buffer can still accept.
   assign push      = MemWrite && in_win && (!full || pop);
   assign drop      = MemWrite && in_win && full && !pop;

   assign out_addr = out_valid ? mem[rd_ptr][63:32] : 32'h0;
   assign out_data = out_valid ? mem[rd_ptr][31:0]  : 32'h0;

   // NOTE: storage is deliberately left out of reset; count gates every read,
   // so stale contents are never visible and the array can map to plain RAM.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {ALUResult, WriteData};
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
         // A drop in the same cycle outranks a clear request.
         if (drop)              overflow <= 1'b1;
         else if (clr_overflow) overflow <= 1'b0;
      end
   end

endmodule
